// File: rtl/pattern_serializer.sv
// pattern_serializer: parallel-to-serial front end for the 10010 sequence
// detector. Words arrive over a valid/ready handshake into a one-word holding
// register and leave one bit per clock on a registered bit_out/bit_valid pair.
// The holding register refills while the shifter drains, so back-to-back
// words stream with no idle cycle between them.
module pattern_serializer #(
  parameter int DATA_W    = 8,     // word width, 2 or more
  parameter bit MSB_FIRST = 1'b1   // 1: bit DATA_W-1 leaves first; 0: bit 0 first
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active-high
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              word_done,
  output logic              busy
);

  // rem counts bits still waiting in the shifter; it never needs to hold
  // DATA_W because the first bit of a word leaves on the Load edge itself.
  localparam int REM_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [REM_W-1:0] REM_ZERO = '0;
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(DATA_W - 1);

  // Per-edge action, one of three, chosen in priority order Shift > Load > Idle.
  localparam logic [1:0] ACT_IDLE  = 2'd0;
  localparam logic [1:0] ACT_LOAD  = 2'd1;
  localparam logic [1:0] ACT_SHIFT = 2'd2;

  // Holding register and its occupancy flag.
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;

  // Shifter and its remaining-bit count.
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [REM_W-1:0]  rem_q, rem_d;

  // Registered serial outputs.
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic word_done_q, word_done_d;

  logic [1:0] act;
  logic       accept;

  // Bit that leaves first from a word, according to the configured order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // The word with its first bit consumed; the vacated position fills with 0.
  function automatic logic [DATA_W-1:0] consume(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Handshake and status outputs, combinational from registers and rst.
  // Holding ready low during reset keeps upstream from believing a word was
  // taken on an edge that discards it.
  assign din_ready = !hold_full_q && !rst;
  assign accept    = din_valid && din_ready;
  assign busy      = hold_full_q || (rem_q != REM_ZERO);

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign word_done = word_done_q;

  // Pick this edge's action: drain the shifter first, then refill it from hold.
  always_comb begin
    act = ACT_IDLE;
    if (rem_q != REM_ZERO) begin
      act = ACT_SHIFT;
    end else if (hold_full_q) begin
      act = ACT_LOAD;
    end
  end

  // Next-state logic for the shifter, holding register and serial outputs.
  always_comb begin
    // NOTE: every target gets a default before any branch so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;

    case (act)
      ACT_SHIFT: begin
        bit_out_d   = first_bit(sh_q);
        bit_valid_d = 1'b1;
        sh_d        = consume(sh_q);
        rem_d       = rem_q - REM_ONE;
        word_done_d = (rem_q == REM_ONE);
      end
      ACT_LOAD: begin
        // The first bit goes straight out of hold so a held word follows the
        // previous word's last bit with no gap.
        bit_out_d   = first_bit(hold_q);
        bit_valid_d = 1'b1;
        sh_d        = consume(hold_q);
        rem_d       = REM_LOAD;
        hold_full_d = 1'b0;
      end
      default: begin
        // Idle: outputs stay at their zero defaults.
      end
    endcase

    // din_ready is low whenever hold is occupied, so an accept never meets a
    // Load; an accept during a Shift simply parks the word in hold.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      hold_full_q <= 1'b0;
      rem_q       <= REM_ZERO;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      rem_q       <= rem_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  // Data registers for the held word and the shifter.
  always_ff @(posedge clk) begin
    // NOTE: the data words are deliberately left out of reset; their contents
    // are only observed while hold_full or rem qualifies them, and both of
    // those flags are reset.
    hold_q <= hold_d;
    sh_q   <= sh_d;
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer. Two instances share one input
// stream (MSB-first and LSB-first). Each accepted word is expanded into its
// expected bit sequence in a scoreboard queue; a monitor pops and compares
// whenever a DUT presents a bit. Expected timing follows from the queue alone:
// a bit must appear after every edge that begins with undelivered bits, and
// the holding register is full exactly when a whole word or more is pending.
module tb_pattern_serializer;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              din_valid;

  logic din_ready, bit_out, bit_valid, word_done, busy;
  logic din_ready_l, bit_out_l, bit_valid_l, word_done_l, busy_l;

  exp_t q_msb[$];
  logic q_lsb[$];
  int   prev_size;

  int n_cmp;
  int n_bad;

  // Stream log used for the end-to-end detector check.
  logic        log_on;
  logic [15:0] slog;
  int          scnt;

  pattern_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  pattern_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_l),
    .bit_out   (bit_out_l),
    .bit_valid (bit_valid_l),
    .word_done (word_done_l),
    .busy      (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand an accepted word into the bit sequences both instances must emit.
  task automatic push_word(input logic [DATA_W-1:0] w);
    exp_t e;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      e.b    = w[i];
      e.last = (i == 0);
      q_msb.push_back(e);
    end
    for (int i = 0; i < DATA_W; i++) begin
      q_lsb.push_back(w[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = DATA_W'($urandom);
    end
  endtask

  // Offer a word until accepted; junk is driven on din while not ready.
  task automatic send_word(input logic [DATA_W-1:0] w);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      #1;
      din_valid = 1'b1;
      if (din_ready) begin
        din = w;
        push_word(w);
        done = 1'b1;
      end else begin
        din = DATA_W'($urandom);
      end
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_pulse(input int n);
    repeat (n) begin
      @(negedge clk);
      rst       = 1'b1;
      din_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic lb;
    #1;
    if (rst) begin
      check("rst_bit_valid", bit_valid, 0);
      check("rst_word_done", word_done, 0);
      check("rst_din_ready", din_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_bit_valid_lsb", bit_valid_l, 0);
      check("rst_busy_lsb", busy_l, 0);
      q_msb.delete();
      q_lsb.delete();
      prev_size = 0;
    end else begin
      check("bit_valid", bit_valid, prev_size > 0);
      check("bit_valid_lsb", bit_valid_l, prev_size > 0);
      if (bit_valid && q_msb.size() > 0) begin
        e = q_msb.pop_front();
        check("bit_out", bit_out, e.b);
        check("word_done", word_done, e.last);
        if (q_lsb.size() > 0) begin
          lb = q_lsb.pop_front();
          check("bit_out_lsb", bit_out_l, lb);
          check("word_done_lsb", word_done_l, e.last);
        end
        if (log_on && scnt < 16) begin
          slog[scnt] = bit_out;
          scnt++;
        end
      end else if (!bit_valid) begin
        check("idle_bit_out", bit_out, 0);
        check("idle_word_done", word_done, 0);
      end
      check("busy", busy, q_msb.size() > 0);
      check("din_ready", din_ready, q_msb.size() < DATA_W);
      check("busy_lsb", busy_l, q_msb.size() > 0);
      check("din_ready_lsb", din_ready_l, q_msb.size() < DATA_W);
      prev_size = q_msb.size();
    end
  end

  // Stimulus.
  initial begin
    logic [15:0] det;
    n_cmp     = 0;
    n_bad     = 0;
    prev_size = 0;
    log_on    = 1'b0;
    slog      = '0;
    scnt      = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single word, then a gap long enough to see bit_valid drop.
    send_word(8'h90);
    idle(12);

    // Back-to-back with din_valid held high.
    send_word(8'hA5);
    send_word(8'h3C);
    idle(20);

    // LSB-first instance must emit 1,0,0,0,0,0,0,0 for this word.
    send_word(8'h01);
    idle(12);

    // Reset after three bits of 8'hFF with 8'h55 already held.
    send_word(8'hFF);
    send_word(8'h55);
    idle(1);
    reset_pulse(2);
    send_word(8'h12);
    idle(12);

    // End-to-end with a reference 10010 detector applied to the stream.
    log_on = 1'b1;
    scnt   = 0;
    send_word(8'h92);
    send_word(8'h48);
    idle(20);
    log_on = 1'b0;
    check("stream_len", scnt, 16);
    det = '0;
    for (int p = 5; p <= 16; p++) begin
      if ({slog[p-5], slog[p-4], slog[p-3], slog[p-2], slog[p-1]} == 5'b10010)
        det[p-1] = 1'b1;
    end
    check("detector_hits", det, 16'h2490);

    // Randomized words with random gaps.
    repeat (60) begin
      send_word(DATA_W'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
    end

    // Drain with a bounded wait.
    idle(1);
    for (int t = 0; t < 64 && busy; t++) @(negedge clk);
    idle(2);
    check("drain_busy", busy, 0);
    check("drain_queue", q_msb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial front end for the 10010 sequence detector. It accepts parallel words over a valid/ready handshake and emits them one bit per clock as a registered `bit_out`/`bit_valid` stream, which drives the detector's `in`/`valid` pair directly. A one-word holding register lets consecutive words stream with no idle cycle between them.

## Interface
- `DATA_W`, 8: word width in bits; legal values are 2 or more.
- `MSB_FIRST`, 1: 1 sends bit `DATA_W-1` first; 0 sends bit 0 first.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  DATA_W  parallel word; sampled only on an accepted transfer.
- `din_valid`  input  1  upstream has a word on `din`.
- `din_ready`  output  1  holding register empty; equals `!hold_full && !rst`.
- `bit_out`  output  1  registered serial bit; connects to detector `in`.
- `bit_valid`  output  1  registered qualifier for `bit_out`; connects to detector `valid`.
- `word_done`  output  1  registered one-cycle pulse issued together with the last bit of each word.
- `busy`  output  1  `hold_full || rem != 0`; combinational from registers.

## Operation
- Internal state:
  - `hold[DATA_W-1:0]`, `hold_full`: the holding register and its occupancy flag.
  - `sh[DATA_W-1:0]`: the shifter.
  - `rem`: bits remaining in the shifter, width `$clog2(DATA_W)`, range 0..DATA_W-1.
- Accept: on an edge where `din_valid && din_ready`, `hold <= din` and `hold_full <= 1`.
- Each non-reset edge takes exactly one of three actions, in priority order:
  - Shift (`rem != 0`):
    - `bit_out <=` the next bit of `sh` (MSB or LSB according to `MSB_FIRST`); `bit_valid <= 1`.
    - `sh` shifts by one; `rem <= rem-1`.
    - `word_done <= (rem == 1)`.
  - Load (`rem == 0 && hold_full`):
    - `bit_out <=` the first bit of `hold`; `bit_valid <= 1`.
    - `sh <=` `hold` with its first bit consumed; `rem <= DATA_W-1`.
    - `hold_full <= 0`; `word_done <= 0`.
  - Idle (otherwise): `bit_valid <= 0`, `bit_out <= 0`, `word_done <= 0`.
- Simultaneous events:
  - No accept and load can coincide: `din_ready` is 0 whenever `hold_full` is 1.
  - An accept coincident with a Shift edge is legal. The new word waits in `hold`.
- Data integrity: no word is dropped, duplicated or reordered. `din` is ignored whenever `din_ready` is 0.
- No backpressure from downstream; the detector consumes one bit every cycle.

## Timing
- Reset (`rst` high at an edge):
  - Registers: `bit_out`, `bit_valid`, `word_done`, `hold_full` all 0; `rem` 0.
  - While `rst` is high: `din_ready` is 0 and `busy` is 0 after the first reset edge.
- Reset mid-word: the partial word and any held word are discarded. The stream stops at the next edge with no truncated `word_done`.
- Latency:
  - A word accepted at edge k gives its first `bit_valid` after edge k+1, provided the shifter is idle.
  - Its last bit and `word_done` follow after edge k+DATA_W.
- `din_ready` timing:
  - Falls after the accept edge.
  - Rises after the Load edge that empties `hold`.
  - After that rise, upstream has DATA_W-1 cycles to present the next word and keep the stream gapless.
- Gapless streaming: if `hold_full` is 1 when `rem` reaches 0, the next word's first bit follows the previous word's last bit in the very next cycle.
- Sustained throughput: one word per DATA_W cycles.
- Idle gaps: between words with no held data, `bit_valid` is 0 for every cycle with nothing to send.

## Test plan
- Single word, defaults, `din`=8'h90 accepted at edge k:
  - `bit_out` = 1,0,0,1,0,0,0,0 with `bit_valid`=1 after edges k+1..k+8.
  - `word_done` is 1 only after k+8; `bit_valid` is 0 after k+9.
- Back-to-back, `din_valid` held high with 8'hA5 then 8'h3C:
  - 16 contiguous `bit_valid` cycles: 10100101 then 00111100.
  - `din_ready` is low between each accept and the following Load.
  - `busy` is 0 afterwards.
- `MSB_FIRST`=0, `din`=8'h01: `bit_out` = 1,0,0,0,0,0,0,0.
- `din_valid` high with a changing `din` while `din_ready`=0: only the values present on accept edges appear on the stream, each exactly once.
- Reset after 3 bits of 8'hFF with a second word already held:
  - `bit_valid`=0, `din_ready`=0 and `busy`=0 after the reset edge.
  - After release, a new word 8'h12 is accepted and serialized from its first bit, with no residue.
- End-to-end with the detector, words 8'h92 then 8'h48 (stream 1001001001001000):
  - Detector `out` pulses at each completed overlapping 10010: after bits 5, 8, 11 and 14 of the stream.
